// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int DEF_ADDR_W     = 8;
  localparam int WORD_IDX_W     = DEF_ADDR_W - BYTE_IDX_W;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian 4-lane byte assembler; word_o already includes the byte being loaded.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [BYTE_IDX_W-1:0] idx_q;
  logic [BYTE_IDX_W-1:0] idx_d;
  logic [7:0]            lane_q [BYTES_PER_WORD];

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (load) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic hit;
      assign hit = load && (idx_q == BYTE_IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_q[gi] <= '0;
        end else if (clear) begin
          lane_q[gi] <= '0;
        end else if (hit) begin
          lane_q[gi] <= byte_in;
        end
      end

      // Bypass lets the writer capture the full word on the 4th byte's edge.
      assign word[gi*8 +: 8] = hit ? byte_in : lane_q[gi];
    end
  endgenerate

  assign last_byte = load && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: count header, little-endian words, XOR trailer -> imem write port.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int         WI_W  = ADDR_W - BYTE_IDX_W;
  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [7:0]        chk_q, chk_d;
  logic [WI_W-1:0]   widx_q, widx_d;
  logic [WI_W-1:0]   last_idx_q, last_idx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              start_ok;
  logic              asm_load;
  logic              asm_clear;
  logic [31:0]       asm_word;
  logic              asm_last;

  assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign asm_load  = (state_q == DATA) && rx_valid;
  assign asm_clear = start_ok || ((state_q == COUNT) && rx_valid);

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (reset),
    .load      (asm_load),
    .clear     (asm_clear),
    .byte_in   (rx_data),
    .word      (asm_word),
    .last_byte (asm_last)
  );

  always_comb begin
    state_d    = state_q;
    chk_d      = chk_q;
    widx_d     = widx_q;
    last_idx_d = last_idx_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    rx_ready   = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = COUNT;
          chk_d   = '0;
          widx_d  = '0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      COUNT: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          chk_d = rx_data;
          if (rx_data == 8'd0 || rx_data > MAX_N) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            last_idx_d = WI_W'(rx_data - 8'd1);
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          chk_d = chk_q ^ rx_data;
          if (asm_last) begin
            state_d   = WRITE;
            wr_addr_d = {widx_q, {BYTE_IDX_W{1'b0}}};
            wr_data_d = asm_word;
          end
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        widx_d  = widx_q + 1'b1;
        state_d = (widx_q == last_idx_q) ? CHECK : DATA;
      end
      CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      chk_q      <= '0;
      widx_q     <= '0;
      last_idx_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_q      <= chk_d;
      widx_q     <= widx_d;
      last_idx_q <= last_idx_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It is the write end of the instruction fetch path that the PC/adder reads.
- Accepts a byte stream (count header, little-endian instruction bytes, XOR checksum trailer) over a valid/ready handshake.
- Assembles 32-bit words and drives the instruction memory write port at word-aligned byte addresses matching the 8-bit PC.
- Holds the processor (cpu_hold) until a load completes cleanly.

Parameters:
ADDR_W, 8, byte-address width of instruction memory (matches PC width)
MAX_WORDS, 64, largest legal word count (2^(ADDR_W-2))

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  single-cycle pulse; begins a load session
rx_data  input  8  incoming stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  ADDR_W  byte address, always word aligned (bits[1:0]=0)
wr_data  output  32  assembled instruction word
cpu_hold  output  1  1 = keep processor PC in reset
done  output  1  load completed, checksum good
error  output  1  load aborted (bad count or bad checksum)

Behaviour:
- Byte transfer occurs when rx_valid && rx_ready on a rising clk edge. Stalls on either side are legal; no byte is lost or duplicated.
- Reset (reset=0, async): state IDLE. Outputs: rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0. Counters and checksum are cleared.
- States:
  - IDLE: rx_ready=0. On start, go to COUNT and clear the checksum and word index.
  - COUNT: rx_ready=1. Accept byte N and set chk=N.
    - If N==0 or N>MAX_WORDS, go to ERR.
    - Otherwise go to DATA with byte_idx=0.
  - DATA: rx_ready=1. Accept a byte into lane byte_idx (byte 0 goes to bits[7:0], little-endian) and update chk^=byte.
    - On the 4th byte (byte_idx==3), go to WRITE.
  - WRITE: exactly one cycle with rx_ready=0 and wr_en=1.
    - wr_addr = word_idx*4 (truncated to ADDR_W). wr_data = the assembled word.
    - Then word_idx++. If word_idx==N-1, go to CHECK; else go to DATA.
    - The first word writes to address 0; the last legal word (63) writes to address 0xFC, with no wrap.
  - CHECK: rx_ready=1. Accept the trailer byte. If it equals chk, go to DONE; else go to ERR.
  - DONE: done=1, cpu_hold=0, rx_ready=0.
  - ERR: error=1, cpu_hold=1, rx_ready=0. Words already written are not rolled back.
- start behaviour:
  - In DONE or ERR, start clears done/error, asserts cpu_hold=1 in the next cycle, and goes to COUNT.
  - start in COUNT, DATA, WRITE or CHECK is ignored.
- cpu_hold, done and error are registered outputs. cpu_hold falls in the same cycle that done rises.
- Latency: wr_en rises in the cycle after the handshake of the 4th byte of each word. The minimum session is N*5+2 cycles after start.
- wr_en is never asserted outside WRITE. wr_addr and wr_data hold their last values outside WRITE.
- Reset mid-session aborts immediately to reset values. A partial word is never written.

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR)
  - BYTES_PER_WORD=4
  - widths of word_idx and byte_idx
- Sub-module word_assembler: a 4-lane byte shift/assembly register with a lane index. It takes load, clear and byte_in and outputs word and last_byte.
- The FSM, checksum and address counter stay in the top level.

Test Plan:
- Clean load: start, then bytes 02, 13,00,00,00, 93,00,10,00, chk=02^13^93^10=0x92.
  - Required: wr_en pulses twice, writing (0x00, 0x00000013) then (0x04, 0x00100093).
  - Then done=1 and cpu_hold=0.
- Bad checksum: same stream with trailer 0x00 -> both words written; error=1, done=0, cpu_hold=1.
- Illegal count: count byte 0x00, then separately 0x41 (65) -> ERR directly from COUNT with no wr_en. A count of 0x40 loads 64 words, the last to address 0xFC.
- Backpressure and gaps: random rx_valid gaps; drive rx_valid=1 during the WRITE cycle.
  - Required: the byte is accepted only in the cycle after WRITE; data is identical to the clean load.
- Reset mid-load: assert reset=0 after 6 data bytes.
  - Required: outputs return to reset values asynchronously, with no write of the partial word.
  - A subsequent clean load succeeds.
- Restart and ignored start: pulse start mid-DATA (ignored), then after DONE.
  - Required: cpu_hold=1 again the next cycle, and the second load writes from address 0.
